// File: rtl/xbus_arbiter.sv
// ---------------------------------------------------------------------------
// xbus_arbiter
//
// Two-master, one-slave arbiter for the single-cycle xbus. Master 0 (CPU
// core) and master 1 (DMA / debug loader) share one xbus slave port. At
// most one master is granted per cycle, and the granted access completes in
// that same cycle because slave read data is combinational.
//
// Fairness: a master that owns the bus may keep it for up to MAX_BURST
// consecutive cycles while the other master is requesting. After that,
// ties are broken round-robin against the most recently granted master.
//
// Optional build macro:
//   XBUS_ARB_FIXED_PRIO_EN - ties go to master 0 instead of round-robin and
//                            the round-robin history register is removed.
//                            Master 1 still gets one cycle once master 0
//                            has used up its burst.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   mX_req/we/be/addr/wdata    master X request and payload (X = 0, 1)
//   mX_gnt                     master X granted; access completes this cycle
//   mX_rdata                   master X read data (0 unless granted)
//   xbus_as/we/be/addr/wdata   slave-side strobe and payload (0 when idle)
//   xbus_rdata                 slave read data, combinational from xbus_addr
// ---------------------------------------------------------------------------
module xbus_arbiter #(
    parameter int ADDRW     = 32,
    parameter int DATAW     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m0_req,
    input  logic               m0_we,
    input  logic [DATAW/8-1:0] m0_be,
    input  logic [ADDRW-1:0]   m0_addr,
    input  logic [DATAW-1:0]   m0_wdata,
    output logic               m0_gnt,
    output logic [DATAW-1:0]   m0_rdata,
    input  logic               m1_req,
    input  logic               m1_we,
    input  logic [DATAW/8-1:0] m1_be,
    input  logic [ADDRW-1:0]   m1_addr,
    input  logic [DATAW-1:0]   m1_wdata,
    output logic               m1_gnt,
    output logic [DATAW-1:0]   m1_rdata,
    output logic               xbus_as,
    output logic               xbus_we,
    output logic [DATAW/8-1:0] xbus_be,
    output logic [ADDRW-1:0]   xbus_addr,
    output logic [DATAW-1:0]   xbus_wdata,
    input  logic [DATAW-1:0]   xbus_rdata
);

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    owner_e     owner_q, owner_d;
    logic [7:0] cnt_q, cnt_d;
    logic       gnt0_raw, gnt1_raw;
    logic       burst_ok;

`ifndef XBUS_ARB_FIXED_PRIO_EN
    // 0 = master 0 granted most recently, 1 = master 1.
    logic last_q, last_d;
`endif

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c >= MAX_B) ? c : c + 8'd1;
    endfunction

    // Grant selection: lone requester wins outright; under contention the
    // owner holds until its burst is used up, then the tie-break decides.
    always_comb begin
        gnt0_raw = 1'b0;
        gnt1_raw = 1'b0;
        burst_ok = (cnt_q < MAX_B);
        if (m0_req && !m1_req) begin
            gnt0_raw = 1'b1;
        end else if (!m0_req && m1_req) begin
            gnt1_raw = 1'b1;
        end else if (m0_req && m1_req) begin
`ifdef XBUS_ARB_FIXED_PRIO_EN
            // Master 1 only ever gets a single cycle under contention, so
            // only master 0 can hold a burst; once it hits the limit the
            // bus goes to master 1 for one cycle.
            if (owner_q == OWN_M0 && !burst_ok) begin
                gnt1_raw = 1'b1;
            end else begin
                gnt0_raw = 1'b1;
            end
`else
            if (owner_q == OWN_M0 && burst_ok) begin
                gnt0_raw = 1'b1;
            end else if (owner_q == OWN_M1 && burst_ok) begin
                gnt1_raw = 1'b1;
            end else if (last_q) begin
                gnt0_raw = 1'b1;
            end else begin
                gnt1_raw = 1'b1;
            end
`endif
        end
    end

    // Reset must drop grants within the cycle it is asserted, not at the
    // next edge, so grants are masked combinationally.
    assign m0_gnt = gnt0_raw & ~rst;
    assign m1_gnt = gnt1_raw & ~rst;

    always_comb begin
        owner_d = OWN_NONE;
        cnt_d   = 8'd0;
`ifndef XBUS_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        if (gnt0_raw) begin
            owner_d = OWN_M0;
            cnt_d   = (owner_q == OWN_M0) ? sat_inc(cnt_q) : 8'd1;
`ifndef XBUS_ARB_FIXED_PRIO_EN
            last_d  = 1'b0;
`endif
        end else if (gnt1_raw) begin
            owner_d = OWN_M1;
            cnt_d   = (owner_q == OWN_M1) ? sat_inc(cnt_q) : 8'd1;
`ifndef XBUS_ARB_FIXED_PRIO_EN
            last_d  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_NONE;
            cnt_q   <= 8'd0;
`ifndef XBUS_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;   // master 0 wins the first tie
`endif
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
`ifndef XBUS_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    // Slave mux: everything is forced to 0 when idle so the bus never
    // carries stale payload from a non-granted master.
    always_comb begin
        xbus_as    = 1'b0;
        xbus_we    = 1'b0;
        xbus_be    = '0;
        xbus_addr  = '0;
        xbus_wdata = '0;
        if (m0_gnt) begin
            xbus_as    = 1'b1;
            xbus_we    = m0_we;
            xbus_be    = m0_be;
            xbus_addr  = m0_addr;
            xbus_wdata = m0_wdata;
        end else if (m1_gnt) begin
            xbus_as    = 1'b1;
            xbus_we    = m1_we;
            xbus_be    = m1_be;
            xbus_addr  = m1_addr;
            xbus_wdata = m1_wdata;
        end
    end

    assign m0_rdata = m0_gnt ? xbus_rdata : '0;
    assign m1_rdata = m1_gnt ? xbus_rdata : '0;

endmodule

// File: tb/tb_xbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xbus_arbiter
//
// Table-driven bench for xbus_arbiter (default build, MAX_BURST = 4).
// Each record carries one cycle of inputs plus the expected grant pair;
// the remaining expected outputs are derived from the record by a small
// model and queued when the stimulus is driven, then popped and compared
// at mid-cycle. Hand-written sequences cover sustained contention and an
// asynchronous reset asserted between clock edges.
// ---------------------------------------------------------------------------
module tb_xbus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    typedef struct packed {
        logic          rst;
        logic          r0;
        logic          w0;
        logic [BW-1:0] be0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1;
        logic          w1;
        logic [BW-1:0] be1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic [DW-1:0] rd;
        logic          e0;
        logic          e1;
    } vec_t;

    typedef struct packed {
        logic          g0;
        logic          g1;
        logic          as_;
        logic          we;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [BW-1:0] m0_be, m1_be;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          xbus_as, xbus_we;
    logic [BW-1:0] xbus_be;
    logic [AW-1:0] xbus_addr;
    logic [DW-1:0] xbus_wdata;
    logic [DW-1:0] xbus_rdata;

    int   n_applied;
    int   n_miscomp;
    exp_t sb[$];
    vec_t tbl[27];

    xbus_arbiter #(.ADDRW(AW), .DATAW(DW), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
        .xbus_as(xbus_as), .xbus_we(xbus_we), .xbus_be(xbus_be),
        .xbus_addr(xbus_addr), .xbus_wdata(xbus_wdata),
        .xbus_rdata(xbus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(
        input logic rs,
        input logic r0, input logic w0, input logic [BW-1:0] be0,
        input logic [AW-1:0] a0, input logic [DW-1:0] d0,
        input logic r1, input logic w1, input logic [BW-1:0] be1,
        input logic [AW-1:0] a1, input logic [DW-1:0] d1,
        input logic [DW-1:0] rd, input logic e0, input logic e1);
        vec_t v;
        v.rst = rs; v.r0 = r0; v.w0 = w0; v.be0 = be0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.be1 = be1; v.a1 = a1; v.d1 = d1;
        v.rd = rd; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    // Expected outputs given which master should hold the grant.
    function automatic exp_t model(input vec_t v);
        exp_t e;
        e = '0;
        e.g0 = v.e0;
        e.g1 = v.e1;
        if (v.e0) begin
            e.as_ = 1'b1; e.we = v.w0; e.be = v.be0; e.addr = v.a0;
            e.wdata = v.d0; e.rd0 = v.rd;
        end else if (v.e1) begin
            e.as_ = 1'b1; e.we = v.w1; e.be = v.be1; e.addr = v.a1;
            e.wdata = v.d1; e.rd1 = v.rd;
        end
        return e;
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst;
        m0_req = v.r0; m0_we = v.w0; m0_be = v.be0; m0_addr = v.a0; m0_wdata = v.d0;
        m1_req = v.r1; m1_we = v.w1; m1_be = v.be1; m1_addr = v.a1; m1_wdata = v.d1;
        xbus_rdata = v.rd;
        sb.push_back(model(v));
    endtask

    task automatic check(input string name);
        exp_t e;
        exp_t a;
        n_applied++;
        if (sb.size() == 0) begin
            n_miscomp++;
            $display("FAIL %s: got empty scoreboard, required a queued expectation", name);
        end else begin
            e = sb.pop_front();
            a.g0 = m0_gnt; a.g1 = m1_gnt; a.as_ = xbus_as; a.we = xbus_we;
            a.be = xbus_be; a.addr = xbus_addr; a.wdata = xbus_wdata;
            a.rd0 = m0_rdata; a.rd1 = m1_rdata;
            if (a !== e) begin
                n_miscomp++;
                $display("FAIL %s: got gnt=%b%b as=%b we=%b be=%h addr=%h wd=%h rd0=%h rd1=%h, required gnt=%b%b as=%b we=%b be=%h addr=%h wd=%h rd0=%h rd1=%h",
                         name, a.g0, a.g1, a.as_, a.we, a.be, a.addr, a.wdata, a.rd0, a.rd1,
                         e.g0, e.g1, e.as_, e.we, e.be, e.addr, e.wdata, e.rd0, e.rd1);
            end
        end
    endtask

    task automatic step(input vec_t v, input string name);
        @(posedge clk);
        #1;
        drive(v);
        #4;
        check(name);
    endtask

    initial begin
        n_applied = 0;
        n_miscomp = 0;
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_be = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_be = '0; m1_addr = '0; m1_wdata = '0;
        xbus_rdata = '0;

        //             rst r0 w0 be0    a0            d0            r1 w1 be1    a1            d1            rd            e0 e1
        tbl[0]  = mk(1, 1, 0, 4'hF, 32'h0000_1000, 32'h0,        1, 0, 4'hF, 32'h0000_0100, 32'h0,        32'h1111_1111, 0, 0);
        tbl[1]  = mk(0, 1, 0, 4'hF, 32'h0000_1000, 32'h0,        1, 0, 4'hF, 32'h0000_0100, 32'h0,        32'h1111_1111, 1, 0);
        tbl[2]  = mk(0, 1, 0, 4'hF, 32'h0000_1004, 32'h0,        1, 0, 4'hF, 32'h0000_0100, 32'h0,        32'h2222_2222, 1, 0);
        tbl[3]  = mk(0, 1, 0, 4'hF, 32'h0000_1008, 32'h0,        1, 0, 4'hF, 32'h0000_0100, 32'h0,        32'h3333_3333, 1, 0);
        tbl[4]  = mk(0, 1, 0, 4'hF, 32'h0000_100C, 32'h0,        1, 0, 4'hF, 32'h0000_0100, 32'h0,        32'h4444_4444, 1, 0);
        tbl[5]  = mk(0, 1, 0, 4'hF, 32'h0000_1010, 32'h0,        1, 0, 4'hF, 32'h0000_0100, 32'h0,        32'h5555_5555, 0, 1);
        tbl[6]  = mk(0, 1, 0, 4'hF, 32'h0000_1010, 32'h0,        1, 0, 4'hF, 32'h0000_0104, 32'h0,        32'h6666_6666, 0, 1);
        tbl[7]  = mk(0, 1, 0, 4'hF, 32'h0000_1010, 32'h0,        1, 0, 4'hF, 32'h0000_0108, 32'h0,        32'h7777_7777, 0, 1);
        tbl[8]  = mk(0, 1, 0, 4'hF, 32'h0000_1010, 32'h0,        1, 0, 4'hF, 32'h0000_010C, 32'h0,        32'h8888_8888, 0, 1);
        tbl[9]  = mk(0, 1, 0, 4'hF, 32'h0000_1010, 32'h0,        1, 0, 4'hF, 32'h0000_0110, 32'h0,        32'h9999_9999, 1, 0);
        tbl[10] = mk(0, 0, 1, 4'hF, 32'h0000_AAAA, 32'hFFFF_0000, 0, 1, 4'hF, 32'h0000_BBBB, 32'h0000_FFFF, 32'hABCD_0000, 0, 0);
        tbl[11] = mk(0, 0, 0, 4'hF, 32'h0000_1000, 32'h0,        1, 0, 4'hF, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1);
        tbl[12] = mk(0, 1, 1, 4'h3, 32'h0000_2000, 32'h0000_1234, 0, 0, 4'hF, 32'h0000_0100, 32'h0,        32'h0BAD_0BAD, 1, 0);
        tbl[13] = mk(0, 1, 0, 4'hF, 32'h0000_2004, 32'h0,        0, 0, 4'hF, 32'h0000_0100, 32'h0,        32'h0000_2004, 1, 0);
        tbl[14] = mk(0, 0, 1, 4'h3, 32'h0000_2008, 32'h0000_5678, 0, 1, 4'hC, 32'h0000_0200, 32'h0000_9ABC, 32'hFEED_FACE, 0, 0);
        tbl[15] = mk(0, 1, 0, 4'hF, 32'h0000_2008, 32'h0,        1, 0, 4'hF, 32'h0000_0200, 32'h0,        32'hC0DE_0001, 0, 1);
        tbl[16] = mk(0, 1, 0, 4'hF, 32'h0000_2008, 32'h0,        1, 0, 4'hF, 32'h0000_0204, 32'h0,        32'hC0DE_0002, 0, 1);
        tbl[17] = mk(0, 1, 0, 4'hF, 32'h0000_2008, 32'h0,        1, 0, 4'hF, 32'h0000_0208, 32'h0,        32'hC0DE_0003, 0, 1);
        tbl[18] = mk(1, 1, 0, 4'hF, 32'h0000_2008, 32'h0,        1, 0, 4'hF, 32'h0000_020C, 32'h0,        32'hC0DE_0004, 0, 0);
        tbl[19] = mk(0, 1, 0, 4'hF, 32'h0000_3000, 32'h0,        1, 0, 4'hF, 32'h0000_020C, 32'h0,        32'hC0DE_0005, 1, 0);
        tbl[20] = mk(0, 1, 0, 4'hF, 32'h0000_3004, 32'h0,        0, 0, 4'hF, 32'h0000_0000, 32'h0,        32'h0000_0020, 1, 0);
        tbl[21] = mk(0, 1, 0, 4'hF, 32'h0000_3008, 32'h0,        0, 0, 4'hF, 32'h0000_0000, 32'h0,        32'h0000_0021, 1, 0);
        tbl[22] = mk(0, 1, 0, 4'hF, 32'h0000_300C, 32'h0,        0, 0, 4'hF, 32'h0000_0000, 32'h0,        32'h0000_0022, 1, 0);
        tbl[23] = mk(0, 1, 0, 4'hF, 32'h0000_3010, 32'h0,        0, 0, 4'hF, 32'h0000_0000, 32'h0,        32'h0000_0023, 1, 0);
        tbl[24] = mk(0, 1, 0, 4'hF, 32'h0000_3014, 32'h0,        0, 0, 4'hF, 32'h0000_0000, 32'h0,        32'h0000_0024, 1, 0);
        tbl[25] = mk(0, 1, 0, 4'hF, 32'h0000_3018, 32'h0,        1, 0, 4'hF, 32'h0000_0300, 32'h0,        32'h0000_0025, 0, 1);
        tbl[26] = mk(0, 1, 0, 4'hF, 32'h0000_3018, 32'h0,        1, 1, 4'hC, 32'h0000_0304, 32'h0000_CAFE, 32'h0000_0026, 0, 1);

        repeat (2) @(posedge clk);

        for (int i = 0; i < 27; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Sustained contention from reset: M0 x4, M1 x4, repeating.
        step(mk(1, 1, 0, 4'hF, 32'h0, 32'h0, 1, 0, 4'hF, 32'h0, 32'h0, 32'h0, 0, 0), "cont_rst");
        for (int k = 0; k < 16; k++) begin
            logic m0_turn;
            m0_turn = (((k / 4) % 2) == 0);
            step(mk(0, 1, 0, 4'hF, 32'h4000 + k, 32'h0, 1, 0, 4'hF, 32'h8000 + k, 32'h0,
                    32'h5A5A_0000 + k, m0_turn, !m0_turn), $sformatf("cont%0d", k));
        end

        // Build an M1 burst, then assert reset between clock edges.
        step(mk(0, 0, 0, 4'hF, 32'h0, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0, 32'h0, 0, 0), "async_idle");
        step(mk(0, 0, 0, 4'hF, 32'h0, 32'h0, 1, 0, 4'hF, 32'h600, 32'h0, 32'h61, 0, 1), "async_m1a");
        step(mk(0, 1, 0, 4'hF, 32'h500, 32'h0, 1, 0, 4'hF, 32'h604, 32'h0, 32'h62, 0, 1), "async_m1b");
        @(posedge clk);
        #1;
        drive(mk(0, 1, 0, 4'hF, 32'h500, 32'h0, 1, 0, 4'hF, 32'h608, 32'h0, 32'h63, 0, 1));
        #1;
        check("async_pre");
        drive(mk(1, 1, 0, 4'hF, 32'h500, 32'h0, 1, 0, 4'hF, 32'h608, 32'h0, 32'h63, 0, 0));
        #1;
        check("async_drop");
        step(mk(1, 1, 0, 4'hF, 32'h500, 32'h0, 1, 0, 4'hF, 32'h608, 32'h0, 32'h64, 0, 0), "async_hold");
        step(mk(0, 1, 0, 4'hF, 32'h500, 32'h0, 1, 0, 4'hF, 32'h608, 32'h0, 32'h65, 1, 0), "async_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscomp);
        $finish;
    end

endmodule

// File: doc/xbus_arbiter.md
Name: xbus_arbiter

Overview:
- Two-master, one-slave arbiter for the single-cycle xbus.
- Shares one xbus slave port (memory/peripheral fabric) between master 0 (CPU core) and master 1 (DMA or debug loader).
- Each cycle the arbiter grants at most one master and drives the slave-side xbus from it. A granted request completes in that same cycle, since xbus read data is combinational.
- Fairness comes from round-robin tie-breaking plus a burst limit on consecutive ownership.

Parameters:
- ADDRW, 32, address width.
- DATAW, 32, data width. Byte enables are DATAW/8 bits.
- MAX_BURST, 4, maximum consecutive granted cycles for one master while the other is requesting. Legal range 1..255.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 access request; held until granted.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_be  in  DATAW/8  master 0 byte enables.
- m0_addr  in  ADDRW  master 0 address.
- m0_wdata  in  DATAW  master 0 write data.
- m0_gnt  out  1  master 0 granted; the access completes this cycle.
- m0_rdata  out  DATAW  master 0 read data.
- m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_gnt, m1_rdata: same as master 0, for master 1.
- xbus_as  out  1  slave access strobe.
- xbus_we  out  1  slave write enable.
- xbus_be  out  DATAW/8  slave byte enables.
- xbus_addr  out  ADDRW  slave address.
- xbus_wdata  out  DATAW  slave write data.
- xbus_rdata  in  DATAW  slave read data, combinational from xbus_addr.

Behaviour:
- Registered state:
  - owner: NONE/M0/M1, the master granted last cycle.
  - cnt: consecutive granted cycles of owner, 8 bits, saturating at MAX_BURST.
  - last: most recently granted master, for round-robin.
- Reset values (async, while rst=1): owner=NONE, cnt=0, last=M1, so M0 wins the first tie.
- While rst=1: m0_gnt=m1_gnt=0, xbus_as=0, xbus_we=0, xbus_be=0, xbus_addr=0, xbus_wdata=0, mX_rdata=0.
- Grant selection is combinational from the reqs and registered state. Priority order:
  1. No req: no grant.
  2. Exactly one req: grant it (zero-latency, same cycle).
  3. Both req, owner∈{M0,M1} and cnt<MAX_BURST: grant owner (burst hold).
  4. Both req, otherwise: grant the master ≠ last (round-robin).
- Next state:
  - Grant G: owner<=G; cnt<=(G==owner)?min(cnt+1,MAX_BURST):1; last<=G.
  - No grant: owner<=NONE, cnt<=0; last unchanged.
- Slave mux:
  - Granted master's we/be/addr/wdata drive xbus_*, with xbus_as=1.
  - No grant: xbus_as=0 and all other xbus outputs 0, so no bus glitching on an idle bus.
- Read return: mX_rdata=xbus_rdata when mX_gnt=1, else 0.
- Non-granted master keeps req and its payload stable; the arbiter never drops a held request.
- Burst-limit starvation bound: with both masters requesting continuously, neither waits more than MAX_BURST cycles.
- MAX_BURST=1 gives strict alternation under contention.
- Lone requester: cnt saturates at MAX_BURST and that master keeps the bus indefinitely; it yields the first cycle the other requests.
- Owner drops req for one cycle: ownership is lost (owner/cnt reset via the grant rules). A returning request is treated as a new contender.
- Reset asserted mid-burst: state clears immediately and all grants drop in the same cycle.
- One grant per cycle maximum; m0_gnt & m1_gnt is never 1.

Optional Feature:
- Macro XBUS_ARB_FIXED_PRIO_EN.
- Defined: rule 4 always grants M0 and the last register is removed. The burst limit still applies, so while M0 owns the bus M1 gets the bus for one cycle after M0 reaches MAX_BURST.
- Undefined: round-robin as specified above.

Test Plan:
- Reset: rst=1 with both reqs high -> both gnt=0, xbus_as=0. Release rst, both req, both read -> cycle 1 m0_gnt=1, xbus_addr=m0_addr.
- Single master: m1_req=1 read addr 0x100, slave returns 0xDEADBEEF -> m1_gnt=1 same cycle, m1_rdata=0xDEADBEEF, m0_rdata=0.
- Contention, MAX_BURST=4, both req continuously -> grant pattern M0×4, M1×4, M0×4…; no cycle has both gnt.
- Write passthrough: m0 write addr 0x2000, be=4'b0011, wdata=0x1234 -> xbus_we=1, xbus_be=4'b0011, xbus_wdata=0x1234 in grant cycle.
- Idle/drop: m0 owns with cnt=2, m0_req drops one cycle, then both req -> the drop cycle shows xbus_as=0 with all xbus outputs 0; the next grant goes to M1 (last=M0).
- Async reset mid-burst: assert rst between edges during an M1 burst -> m1_gnt falls immediately. After release with both requesting, M0 is granted first.
